// File: rtl/axis_argmax.sv
// axis_argmax: consumes VEC_LEN float32 words per frame and emits the index of the largest one.
// Optional macro ARGMAX_VALUE_OUT_EN appends the maximum value as a second result word.
`timescale 1ns/1ps
module axis_argmax #(
    parameter int VEC_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] INPUT_AXIS_TDATA,
    input  logic        INPUT_AXIS_TLAST,
    input  logic        INPUT_AXIS_TVALID,
    output logic        INPUT_AXIS_TREADY,
    output logic [31:0] OUTPUT_AXIS_TDATA,
    output logic        OUTPUT_AXIS_TLAST,
    output logic        OUTPUT_AXIS_TVALID,
    input  logic        OUTPUT_AXIS_TREADY
);
    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

`ifdef ARGMAX_VALUE_OUT_EN
    typedef enum logic [1:0] {ST_RECV, ST_SEND_IDX, ST_SEND_VAL} state_t;
`else
    typedef enum logic [1:0] {ST_RECV, ST_SEND_IDX} state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      best_key;
    logic [31:0]      best_idx;
`ifdef ARGMAX_VALUE_OUT_EN
    logic [31:0]      best_val;
`endif
    logic [31:0]      in_key;
    logic             in_hs;
    logic             take;
    logic             tlast_unused;

    // Framing is purely by count; the upstream TLAST is not frame-aligned.
    assign tlast_unused = INPUT_AXIS_TLAST;

    // Maps float32 onto an unsigned key whose integer order matches float order,
    // with -0 below +0 and NaNs at the extremes by sign.
    function automatic logic [31:0] order_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    assign in_key = order_key(INPUT_AXIS_TDATA);
    assign in_hs  = INPUT_AXIS_TVALID && INPUT_AXIS_TREADY;
    assign take   = (cnt == '0) || (in_key > best_key);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= ST_RECV;
            cnt      <= '0;
            best_key <= '0;
            best_idx <= '0;
`ifdef ARGMAX_VALUE_OUT_EN
            best_val <= '0;
`endif
        end else begin
            state <= state_next;
            if (in_hs) begin
                cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
                if (take) begin
                    best_key <= in_key;
                    best_idx <= 32'(cnt);
`ifdef ARGMAX_VALUE_OUT_EN
                    best_val <= INPUT_AXIS_TDATA;
`endif
                end
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_next         = state;
        INPUT_AXIS_TREADY  = 1'b0;
        OUTPUT_AXIS_TVALID = 1'b0;
        OUTPUT_AXIS_TDATA  = '0;
        OUTPUT_AXIS_TLAST  = 1'b0;
        case (state)
            ST_RECV: begin
                INPUT_AXIS_TREADY = 1'b1;
                if (INPUT_AXIS_TVALID && cnt == LAST_CNT)
                    state_next = ST_SEND_IDX;
            end
            ST_SEND_IDX: begin
                OUTPUT_AXIS_TVALID = 1'b1;
                OUTPUT_AXIS_TDATA  = best_idx;
`ifdef ARGMAX_VALUE_OUT_EN
                OUTPUT_AXIS_TLAST  = 1'b0;
                if (OUTPUT_AXIS_TREADY)
                    state_next = ST_SEND_VAL;
`else
                OUTPUT_AXIS_TLAST  = 1'b1;
                if (OUTPUT_AXIS_TREADY)
                    state_next = ST_RECV;
`endif
            end
`ifdef ARGMAX_VALUE_OUT_EN
            ST_SEND_VAL: begin
                OUTPUT_AXIS_TVALID = 1'b1;
                OUTPUT_AXIS_TDATA  = best_val;
                OUTPUT_AXIS_TLAST  = 1'b1;
                if (OUTPUT_AXIS_TREADY)
                    state_next = ST_RECV;
            end
`endif
            default: state_next = ST_RECV;
        endcase
    end
endmodule

// File: tb/tb_axis_argmax.sv
// Bench for axis_argmax: directed frames, a float-order reference model and a per-cycle output checker.
// Builds with or without ARGMAX_VALUE_OUT_EN.
`timescale 1ns/1ps
module tb_axis_argmax;
    localparam int VEC_LEN = 8;
`ifdef ARGMAX_VALUE_OUT_EN
    localparam int WPF = 2;
`else
    localparam int WPF = 1;
`endif

    typedef logic [31:0] word_t;
    typedef struct {
        word_t data;
        logic  last;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    word_t       in_data = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    word_t       out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    res_t  exp_q[$];
    word_t part_q[$];
    word_t got_q[$];
    bit    armed = 1'b0;

    word_t f_basic[$];
    word_t f_neg[$];
    word_t f_tie[$];
    word_t f_big[$];
    word_t f_a[$];
    word_t f_b[$];

    axis_argmax #(.VEC_LEN(VEC_LEN)) dut (
        .clk                (clk),
        .rst                (rst),
        .INPUT_AXIS_TDATA   (in_data),
        .INPUT_AXIS_TLAST   (in_last),
        .INPUT_AXIS_TVALID  (in_valid),
        .INPUT_AXIS_TREADY  (in_ready),
        .OUTPUT_AXIS_TDATA  (out_data),
        .OUTPUT_AXIS_TLAST  (out_last),
        .OUTPUT_AXIS_TVALID (out_valid),
        .OUTPUT_AXIS_TREADY (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // True when a is strictly above b in IEEE total order (sign first, then magnitude).
    function automatic bit float_above(input word_t a, input word_t b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic int model_argmax(input word_t v[$]);
        int best = 0;
        for (int i = 1; i < v.size(); i++)
            if (float_above(v[i], v[best])) best = i;
        return best;
    endfunction

    // Reference model and per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        bit model_ready;
        model_ready = (exp_q.size() == 0);
        if (armed && !rst) begin
            check("in_ready", {31'b0, in_ready}, {31'b0, model_ready});
            if (!model_ready) begin
                check("out_valid", {31'b0, out_valid}, 32'd1);
                check("out_data", out_data, exp_q[0].data);
                check("out_last", {31'b0, out_last}, {31'b0, exp_q[0].last});
            end else begin
                check("out_valid_idle", {31'b0, out_valid}, 32'd0);
                check("out_data_idle", out_data, 32'd0);
                check("out_last_idle", {31'b0, out_last}, 32'd0);
            end
        end
        if (rst) begin
            exp_q.delete();
            part_q.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (!model_ready) begin
                if (out_ready) void'(exp_q.pop_front());
            end else if (in_valid) begin
                part_q.push_back(in_data);
                if (part_q.size() == VEC_LEN) begin
                    int idx;
                    idx = model_argmax(part_q);
`ifdef ARGMAX_VALUE_OUT_EN
                    exp_q.push_back('{data: word_t'(idx), last: 1'b0});
                    exp_q.push_back('{data: part_q[idx], last: 1'b1});
`else
                    exp_q.push_back('{data: word_t'(idx), last: 1'b1});
`endif
                    part_q.delete();
                end
            end
        end
    end

    task automatic push(input word_t d, input logic last);
        int budget = 200;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input word_t v[$], input int gap_every, input int tlast_at);
        for (int i = 0; i < v.size(); i++) begin
            push(v[i], i == tlast_at);
            if (gap_every > 0 && (i % gap_every) == 0) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_results(input string name, input int n);
        int budget = 100;
        while (got_q.size() < n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check({"wait_", name}, 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic expect_result(input string name, input word_t idx, input word_t val);
        if (got_q.size() < WPF) begin
            check({name, "_count"}, 32'(got_q.size()), 32'(WPF));
        end else begin
            check({name, "_idx"}, got_q.pop_front(), idx);
`ifdef ARGMAX_VALUE_OUT_EN
            check({name, "_val"}, got_q.pop_front(), val);
`else
            if (val == 32'hFFFF_FFFF) check({name, "_val_unused"}, 32'd0, 32'd1);
`endif
        end
    endtask

    initial begin
        f_basic = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hC0400000,
                    32'h40F00000, 32'h40E00000, 32'h00000000, 32'h3F800000};
        f_neg   = '{32'hBF800000, 32'hBF000000, 32'h80000000, 32'hC0000000,
                    32'h00000000, 32'hFF800000, 32'hC0400000, 32'hBE800000};
        f_tie   = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000,
                    32'h3F800000, 32'h3F800000, 32'h40400000, 32'h3F800000};
        f_big   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h42C80000};
        f_a     = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h41000000,
                    32'h3F000000, 32'h40E00000, 32'h80000000, 32'h40000000};
        f_b     = '{32'h3F800000, 32'h40000000, 32'h7F800000, 32'hFFC00000,
                    32'h3F800000, 32'h00000000, 32'h7FC00000, 32'h40400000};

        // Hand-computed pins on the reference model itself.
        check("model_basic", 32'(model_argmax(f_basic)), 32'd4);
        check("model_neg",   32'(model_argmax(f_neg)),   32'd4);
        check("model_tie",   32'(model_argmax(f_tie)),   32'd1);
        check("model_a",     32'(model_argmax(f_a)),     32'd3);
        check("model_b",     32'(model_argmax(f_b)),     32'd6);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  {31'b0, in_ready},  32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_last",  {31'b0, out_last},  32'd0);
        check("reset_out_data",  out_data,           32'd0);
        @(posedge clk);
        #1;

        send_frame(f_basic, 0, -1);
        wait_results("basic", WPF);
        expect_result("basic", 32'd4, 32'h40F00000);

        send_frame(f_neg, 0, -1);
        wait_results("neg", WPF);
        expect_result("neg", 32'd4, 32'h00000000);

        // Backpressure: result held while the sink stalls, input blocked.
        out_ready = 1'b0;
        send_frame(f_tie, 0, -1);
        in_valid = 1'b1;
        in_data  = 32'h7F800000;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_in_ready",  {31'b0, in_ready},  32'd0);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_out_data",  out_data,           32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
`ifdef ARGMAX_VALUE_OUT_EN
        @(posedge clk);
        #1;
`endif
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        wait_results("tie", WPF);
        expect_result("tie", 32'd1, 32'h40400000);

        // Reset mid-frame: the partial frame must leave no trace.
        push(32'h43FA0000, 1'b0);
        push(32'h3F800000, 1'b0);
        push(32'h3F800000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(f_big, 0, -1);
        wait_results("reset", WPF);
        repeat (4) @(posedge clk);
        #1;
        check("reset_one_result", 32'(got_q.size()), 32'(WPF));
        expect_result("reset", 32'd7, 32'h42C80000);

        // Back-to-back frames with gaps and a stray mid-frame TLAST.
        send_frame(f_a, 3, 3);
        send_frame(f_b, 2, 3);
        wait_results("b2b", 2 * WPF);
        expect_result("frame_a", 32'd3, 32'h41000000);
        expect_result("frame_b", 32'd6, 32'h7FC00000);

        repeat (6) @(posedge clk);
        #1;
        check("no_extra_output", 32'(got_q.size()), 32'd0);
        check("model_drained", 32'(exp_q.size() + part_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
